fetch_stage: RTL and testbench

//   Instruction fetch stage. Sits directly upstream of the decode stage.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_pc.sv | 37 +++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, opcode field
// position, and the two-phase (hi/lo word) fetch state.
package fetch_stage_pkg;

  localparam int HWORD_W = 16;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0]         OPC_NOP   = 5'b00101;
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OPC_NOP, 27'd0};

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
  parameter int PC_W = 16
) ();

  // A word moves in every cycle with imem_req && imem_valid; imem_addr stays
  // stable while imem_req is high, and imem_valid with imem_req low is ignored.
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/fetch_pc.sv
// Word-address program counter: reset, redirect load, or wrap-around increment.
module fetch_pc #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect beats increment so a transfer in the redirect cycle never advances pc.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: reads two 16-bit words (high first), assembles a 32-bit
// instruction for decode, with stall back-pressure and redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_stage_if.master      imem,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output fetch_state_e       state_o
);

  fetch_state_e         state_q;
  logic [HWORD_W-1:0]   hi_buf_q;
  logic [PC_W-1:0]      hi_pc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 instr_valid_q;
  logic [PC_W-1:0]      instr_pc_q;
  logic [PC_W-1:0]      pc;

  logic slot_free;
  logic consumed;
  logic req;
  logic xfer;
  logic hi_xfer;
  logic lo_xfer;

  assign slot_free = !instr_valid_q || !stall_i;
  assign consumed  = instr_valid_q && !stall_i;

  // The hi word is always prefetched; the lo word is only requested when
  // the assembled instruction has somewhere to go.
  assign req     = (state_q == S_HI) || slot_free;
  assign xfer    = req && imem.imem_valid;
  assign hi_xfer = xfer && !redirect_i && (state_q == S_HI);
  assign lo_xfer = xfer && !redirect_i && (state_q == S_LO);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inc_i         (xfer),
    .pc_o          (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HI;
      hi_buf_q      <= '0;
      hi_pc_q       <= '0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
    end else if (redirect_i) begin
      state_q       <= S_HI;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HI: begin
          if (hi_xfer) begin
            hi_buf_q <= imem.imem_rdata;
            hi_pc_q  <= pc;
            state_q  <= S_LO;
          end
        end
        S_LO: begin
          if (lo_xfer) begin
            state_q <= S_HI;
          end
        end
        default: state_q <= S_HI;
      endcase

      if (lo_xfer) begin
        instr_q       <= {hi_buf_q, imem.imem_rdata};
        instr_pc_q    <= hi_pc_q;
        instr_valid_q <= 1'b1;
      end else if (consumed) begin
        instr_q       <= NOP_INSTR;
        instr_valid_q <= 1'b0;
      end
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_pc_o    = instr_pc_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with wait states, scoreboard of
// expected {pc, instr} popped whenever decode consumes an instruction.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int PC_W = 16;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [31:0]        instr;
  logic               instr_valid;
  logic [PC_W-1:0]    instr_pc;
  fetch_state_e       state;

  fetch_stage_if #(.PC_W(PC_W)) mem_if ();

  fetch_stage #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (mem_if.master),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_pc_o    (instr_pc),
    .state_o       (state)
  );

  logic [15:0]      mem [0:65535];
  int               wait_cfg;
  int               wait_cnt;
  logic [47:0]      exp_q[$];
  int               total;
  int               bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_if.imem_rdata = mem[mem_if.imem_addr];
    mem_if.imem_valid = mem_if.imem_req && (wait_cnt >= wait_cfg);
  end

  initial begin
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      if (reset || !mem_if.imem_req || mem_if.imem_valid) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
    end
  end

  // Scoreboard: every consumed instruction must match the head of exp_q.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (!reset && instr_valid && !stall && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({instr_pc, instr} !== e) begin
          bad++;
          $display("FAIL consume got pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, e[47:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [15:0] pc);
    logic [15:0] p1;
    p1 = pc + 16'd1;
    exp_q.push_back({pc, mem[pc], mem[p1]});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    wait_cfg = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total += 6;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
    if (instr !== 32'h2800_0000) begin bad++; $display("FAIL rst_instr got=%h want=28000000", instr); end
    if (instr_pc !== 16'h0) begin bad++; $display("FAIL rst_pc got=%h want=0000", instr_pc); end
    if (mem_if.imem_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0000", mem_if.imem_addr); end
    if (mem_if.imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b want=1", mem_if.imem_req); end
    if (state !== S_HI) begin bad++; $display("FAIL rst_state got=%0d want=%0d", state, S_HI); end
  endtask

  task automatic test_zero_wait();
    logic exp_v;
    apply_reset();
    push_exp(16'd0); push_exp(16'd2); push_exp(16'd4); push_exp(16'd6);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = (c % 2 == 0);
      total++;
      if (instr_valid !== exp_v) begin
        bad++; $display("FAIL zw_valid_c%0d got=%b want=%b", c, instr_valid, exp_v);
      end
      if (c == 2) begin
        total++;
        if ({instr_pc, instr} !== {16'h0000, 32'h0800_0005}) begin
          bad++; $display("FAIL zw_first got=%h/%h want=0000/08000005", instr_pc, instr);
        end
      end
      if (c == 3) begin
        total++;
        if (instr !== 32'h2800_0000) begin bad++; $display("FAIL zw_drain got=%h want=28000000", instr); end
      end
      if (c == 4) begin
        total++;
        if ({instr_pc, instr} !== {16'h0002, 32'h1800_0000}) begin
          bad++; $display("FAIL zw_second got=%h/%h want=0002/18000000", instr_pc, instr);
        end
      end
    end
    drain();
  endtask

  task automatic test_wait_states();
    logic        prev_pend;
    logic [15:0] prev_addr;
    int          n;
    apply_reset();
    wait_cfg = 3;
    push_exp(16'd0); push_exp(16'd2); push_exp(16'd4); push_exp(16'd6);
    reset = 1'b0;
    prev_pend = 1'b0;
    prev_addr = '0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      if (prev_pend && mem_if.imem_req) begin
        total++;
        if (mem_if.imem_addr !== prev_addr) begin
          bad++; $display("FAIL ws_addr_stable got=%h want=%h", mem_if.imem_addr, prev_addr);
        end
      end
      prev_pend = mem_if.imem_req && !mem_if.imem_valid;
      prev_addr = mem_if.imem_addr;
      n++;
    end
    drain();
    wait_cfg = 0;
  endtask

  task automatic test_stall();
    logic saw_lo;
    apply_reset();
    push_exp(16'd0); push_exp(16'd2); push_exp(16'd4);
    reset = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1;
    @(posedge clk);
    saw_lo = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 32'h0800_0005}) begin
        bad++; $display("FAIL st_hold_%0d got=%b/%h/%h want=1/0000/08000005", k, instr_valid, instr_pc, instr);
      end
      if (state == S_LO) begin
        saw_lo = 1'b1;
        total++;
        if (mem_if.imem_req !== 1'b0) begin bad++; $display("FAIL st_req_lo got=%b want=0", mem_if.imem_req); end
      end
      @(posedge clk);
    end
    total += 2;
    if (saw_lo !== 1'b1) begin bad++; $display("FAIL st_prefetch got=%b want=1", saw_lo); end
    if (mem_if.imem_addr !== 16'h0003) begin bad++; $display("FAIL st_pc got=%h want=0003", mem_if.imem_addr); end
    #1;
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0002, 32'h1800_0000}) begin
      bad++; $display("FAIL st_release got=%b/%h/%h want=1/0002/18000000", instr_valid, instr_pc, instr);
    end
    drain();
  endtask

  task automatic test_redirect_lo();
    apply_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    total++;
    if ({state, mem_if.imem_req, mem_if.imem_valid} !== {S_LO, 1'b1, 1'b1}) begin
      bad++; $display("FAIL rd_setup got=%0d/%b/%b want=1/1/1", state, mem_if.imem_req, mem_if.imem_valid);
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total += 3;
    if (mem_if.imem_addr !== 16'h0040) begin bad++; $display("FAIL rd_addr got=%h want=0040", mem_if.imem_addr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b want=0", instr_valid); end
    if (state !== S_HI) begin bad++; $display("FAIL rd_state got=%0d want=0", state); end
    push_exp(16'h0040);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0040}) begin
      bad++; $display("FAIL rd_next got=%b/%h want=1/0040", instr_valid, instr_pc);
    end
    drain();
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL rs_setup got=%b want=1", instr_valid); end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total += 3;
    if (instr !== 32'h2800_0000) begin bad++; $display("FAIL rs_instr got=%h want=28000000", instr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%b want=0", instr_valid); end
    if (mem_if.imem_addr !== 16'h0100) begin bad++; $display("FAIL rs_addr got=%h want=0100", mem_if.imem_addr); end
    push_exp(16'h0100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0100, mem[16'h0100], mem[16'h0101]}) begin
      bad++; $display("FAIL rs_new got=%b/%h/%h want=1/0100/%h%h", instr_valid, instr_pc, instr,
                      mem[16'h0100], mem[16'h0101]);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    drain();
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    reset = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total += 2;
    if (mem_if.imem_addr !== 16'hFFFF) begin bad++; $display("FAIL wr_hi_addr got=%h want=ffff", mem_if.imem_addr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL wr_valid got=%b want=0", instr_valid); end
    push_exp(16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({state, mem_if.imem_addr} !== {S_LO, 16'h0000}) begin
      bad++; $display("FAIL wr_lo_addr got=%0d/%h want=1/0000", state, mem_if.imem_addr);
    end
    drain();
    stall = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== S_LO) begin bad++; $display("FAIL wr_setup_lo got=%0d want=1", state); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total += 5;
    if (state !== S_HI) begin bad++; $display("FAIL mr_state got=%0d want=0", state); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b want=0", instr_valid); end
    if (instr !== 32'h2800_0000) begin bad++; $display("FAIL mr_instr got=%h want=28000000", instr); end
    if (instr_pc !== 16'h0000) begin bad++; $display("FAIL mr_ipc got=%h want=0000", instr_pc); end
    if (mem_if.imem_addr !== 16'h0000) begin bad++; $display("FAIL mr_pc got=%h want=0000", mem_if.imem_addr); end
    stall = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    wait_cfg = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A3C;
    mem[0] = 16'h0800;
    mem[1] = 16'h0005;
    mem[2] = 16'h1800;
    mem[3] = 16'h0000;
    mem[16'hFFFF] = 16'hBEEF;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_lo();
    test_redirect_stall();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
